flex_ff_reg: RTL and testbench

FLEX_FF_REG -- requirements
Module: flex_ff_reg

---
 rtl/flex_ff_reg.sv | 105 ++++++++++
 tb/tb_flex_ff_reg.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/flex_ff_reg.sv
// ---------------------------------------------------------------------------
// flex_ff_reg -- WIDTH-bit register whose bits behave as D, JK, T or SR
// flip-flops, selected per cycle by 'mode'.
//
// Ports:
//   clk      in   1      rising-edge clock
//   rst      in   1      asynchronous active-high reset (q=RST_VAL, chg=0, err=0)
//   en       in   1      update enable; q holds when low (sclr still acts)
//   mode     in   2      00 D, 01 JK, 10 T, 11 SR
//   j        in   WIDTH  D / J / T / S data, depending on mode
//   k        in   WIDTH  K (JK) or R (SR); ignored in D and T modes
//   sclr     in   1      synchronous clear to RST_VAL, overrides en
//   err_clr  in   1      clears the sticky err flag (a same-cycle set wins)
//   q        out  WIDTH  register state
//   qn       out  WIDTH  ~q
//   chg      out  WIDTH  bits that changed on the most recent edge
//   err      out  1      sticky: an SR 11 combination was applied
// ---------------------------------------------------------------------------
module flex_ff_reg #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             sclr,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] chg,
  output logic             err
);

  localparam logic [1:0] MODE_D  = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_T  = 2'b10;
  localparam logic [1:0] MODE_SR = 2'b11;

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] chg_r;
  logic             err_r;
  logic [WIDTH-1:0] q_next_s;
  logic             err_set_s;

  // Next value of every bit for the selected flip-flop flavour.
  // SR: S-only sets, R-only clears, 00 and the illegal 11 both hold.
  function automatic logic [WIDTH-1:0] ff_next(
    input logic [1:0]       m,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] res;
    case (m)
      MODE_D:  res = a;
      MODE_JK: res = (a & ~cur) | (~b & cur);
      MODE_T:  res = cur ^ a;
      MODE_SR: res = (cur & ~(~a & b)) | (a & ~b);
      default: res = cur;
    endcase
    return res;
  endfunction

  // Next-state selection (sclr over en over hold) and illegal-SR detection.
  always_comb begin
    q_next_s  = q_r;
    err_set_s = 1'b0;
    if (sclr) begin
      q_next_s = RST_VAL;
    end else if (en) begin
      q_next_s  = ff_next(mode, q_r, j, k);
      err_set_s = (mode == MODE_SR) && (|(j & k));
    end else begin
      q_next_s = q_r;
    end
  end

  // State, change flags and sticky error; err set takes priority over err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r   <= RST_VAL;
      chg_r <= {WIDTH{1'b0}};
      err_r <= 1'b0;
    end else begin
      q_r   <= q_next_s;
      chg_r <= q_next_s ^ q_r;
      if (err_set_s) begin
        err_r <= 1'b1;
      end else if (err_clr) begin
        err_r <= 1'b0;
      end else begin
        err_r <= err_r;
      end
    end
  end

  assign q   = q_r;
  assign qn  = ~q_r;
  assign chg = chg_r;
  assign err = err_r;

endmodule

// File: tb/tb_flex_ff_reg.sv
// Scoreboard bench for flex_ff_reg (WIDTH=4, RST_VAL=4'b0101).
module tb_flex_ff_reg;

  typedef struct packed {
    logic [3:0] q;
    logic [3:0] chg;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [3:0] j;
  logic [3:0] k;
  logic       sclr;
  logic       err_clr;
  logic [3:0] q;
  logic [3:0] qn;
  logic [3:0] chg;
  logic       err;

  int tests = 0;
  int fails = 0;
  exp_t sb[$];

  flex_ff_reg #(.WIDTH(4), .RST_VAL(4'b0101)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k),
    .sclr(sclr), .err_clr(err_clr), .q(q), .qn(qn), .chg(chg), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue its expected result.
  task automatic step(input logic e, input logic [1:0] m, input logic [3:0] jj,
                      input logic [3:0] kk, input logic sc, input logic ec,
                      input logic [3:0] eq, input logic [3:0] ech, input logic eerr);
    exp_t x;
    @(negedge clk);
    en = e; mode = m; j = jj; k = kk; sclr = sc; err_clr = ec;
    x.q = eq; x.chg = ech; x.err = eerr;
    sb.push_back(x);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #2;
    tests++;
    if (sb.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Independent per-bit reference model used for the mixed-mode run.
  function automatic logic [3:0] model_next(input logic [1:0] m, input logic [3:0] cur,
                                            input logic [3:0] jj, input logic [3:0] kk);
    logic [3:0] r;
    for (int b = 0; b < 4; b++) begin
      case (m)
        2'b00: r[b] = jj[b];
        2'b01: case ({jj[b], kk[b]})
                 2'b10:   r[b] = 1'b1;
                 2'b01:   r[b] = 1'b0;
                 2'b11:   r[b] = ~cur[b];
                 default: r[b] = cur[b];
               endcase
        2'b10: r[b] = jj[b] ? ~cur[b] : cur[b];
        default: case ({jj[b], kk[b]})
                 2'b10:   r[b] = 1'b1;
                 2'b01:   r[b] = 1'b0;
                 default: r[b] = cur[b];
               endcase
      endcase
    end
    return r;
  endfunction

  // Monitor: after every rising edge, compare outputs with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("q", q, e.q);
        chk("qn", qn, ~e.q);
        chk("chg", chg, e.chg);
        chk("err", {3'b000, err}, {3'b000, e.err});
      end
    end
  end

  initial begin
    logic [3:0] mq, nq;
    logic       merr, ee, sc, ec, set;
    logic [3:0] rj, rk;
    logic [1:0] rm;

    rst = 1'b1; en = 1'b0; mode = 2'b00; j = 4'b0000; k = 4'b0000;
    sclr = 1'b0; err_clr = 1'b0;
    #1;
    chk("rst_q", q, 4'b0101);
    chk("rst_qn", qn, 4'b1010);
    chk("rst_chg", chg, 4'b0000);
    chk("rst_err", {3'b000, err}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;

    //    en    mode   j        k        sclr  eclr  q        chg      err
    step(1'b1, 2'b01, 4'b1100, 4'b1010, 1'b0, 1'b0, 4'b1101, 4'b1000, 1'b0); // JK
    step(1'b0, 2'b00, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0101, 4'b1000, 1'b0); // sclr
    step(1'b1, 2'b10, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b1010, 4'b1111, 1'b0); // T
    step(1'b1, 2'b10, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0101, 4'b1111, 1'b0); // T
    step(1'b0, 2'b10, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0101, 4'b0000, 1'b0); // en=0
    step(1'b1, 2'b00, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0101, 1'b0); // D
    step(1'b1, 2'b11, 4'b0011, 4'b0110, 1'b0, 1'b0, 4'b0001, 4'b0001, 1'b1); // SR illegal
    step(1'b1, 2'b11, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0001, 4'b0000, 1'b0); // err_clr
    step(1'b1, 2'b11, 4'b0011, 4'b0110, 1'b0, 1'b1, 4'b0001, 4'b0000, 1'b1); // set wins
    step(1'b1, 2'b11, 4'b0011, 4'b0110, 1'b0, 1'b1, 4'b0001, 4'b0000, 1'b1); // set wins
    step(1'b0, 2'b11, 4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b1); // en=0 hold
    step(1'b1, 2'b00, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b1111, 4'b1110, 1'b1); // D
    step(1'b0, 2'b00, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0101, 4'b1010, 1'b1); // sclr en=0
    step(1'b1, 2'b00, 4'b0101, 4'b0000, 1'b0, 1'b1, 4'b0101, 4'b0000, 1'b0); // clr err
    step(1'b1, 2'b11, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0101, 4'b0000, 1'b0); // sclr masks err
    step(1'b1, 2'b00, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b1111, 4'b1010, 1'b0); // D
    step(1'b1, 2'b00, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0101, 4'b1010, 1'b0); // sclr wins
    step(1'b1, 2'b00, 4'b1010, 4'b0000, 1'b0, 1'b0, 4'b1010, 4'b1111, 1'b0); // D
    step(1'b1, 2'b11, 4'b1000, 4'b1000, 1'b0, 1'b0, 4'b1010, 4'b0000, 1'b1); // SR illegal
    wait_drain();

    // Asynchronous reset between edges with an update pending.
    @(negedge clk);
    en = 1'b1; mode = 2'b00; j = 4'b0011; k = 4'b0000; err_clr = 1'b0; sclr = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_q", q, 4'b0101);
    chk("arst_qn", qn, 4'b1010);
    chk("arst_chg", chg, 4'b0000);
    chk("arst_err", {3'b000, err}, 4'b0000);
    @(negedge clk);
    chk("arst_hold_q", q, 4'b0101);
    en = 1'b0;
    rst = 1'b0;
    step(1'b1, 2'b00, 4'b0011, 4'b0000, 1'b0, 1'b0, 4'b0011, 4'b0110, 1'b0);
    wait_drain();

    // Mode rotates D->JK->T->SR every cycle with random data.
    mq = 4'b0011;
    merr = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      rm = 2'(i % 4);
      rj = 4'($urandom_range(0, 15));
      rk = 4'($urandom_range(0, 15));
      ee = ($urandom_range(0, 7) != 0);
      sc = ($urandom_range(0, 15) == 0);
      ec = ($urandom_range(0, 3) == 0);
      if (sc)      nq = 4'b0101;
      else if (ee) nq = model_next(rm, mq, rj, rk);
      else         nq = mq;
      set = ee && !sc && (rm == 2'b11) && ((rj & rk) != 4'b0000);
      merr = set ? 1'b1 : (ec ? 1'b0 : merr);
      step(ee, rm, rj, rk, sc, ec, nq, nq ^ mq, merr);
      mq = nq;
    end
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
